pack16_rr_arbiter: RTL and testbench

- Shares one 8-to-16 byte packer between two independent byte-stream requesters (s0, s1).
- Each requester delivers bytes in pairs over a valid/ready handshake.
- Round-robin arbitration is performed per pair. The grant stays locked until both bytes of a word are accepted, so bytes from different sources never mix in one word.
- Sits between two byte producers and a 16-bit consumer. The packed word leaves through a registered valid/ready output tagged with its source ID.

---
 rtl/pack16_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_pack16_rr_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pack16_rr_arbiter.sv
// Two-requester byte-pair packer.
// Each requester sends bytes in pairs. Round-robin arbitration picks one
// requester per pair, and its grant stays locked until both bytes of the word
// have been taken. The packed word leaves through a registered valid/ready
// slot, tagged with the requester that produced it.
module pack16_rr_arbiter #(
    parameter int DW         = 8,
    parameter int FIRST_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s0_valid,
    input  logic [DW-1:0]   s0_data,
    output logic            s0_ready,
    input  logic            s1_valid,
    input  logic [DW-1:0]   s1_data,
    output logic            s1_ready,
    output logic            m_valid,
    output logic [2*DW-1:0] m_data,
    output logic            m_src,
    input  logic            m_ready,
    output logic            busy
);

    // state  | meaning
    // IDLE   | no grant held; arbitrate among requesters that are valid
    // FIRST  | grant locked; waiting for the first (high) byte
    // SECOND | grant locked; waiting for the low byte and a free output slot
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } state_t;

    // The last-grant register starts at the opposite of FIRST_PRIO, so
    // FIRST_PRIO wins the first contended arbitration after reset.
    localparam logic LAST_RESET = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

    state_t             state_q;
    logic               grant_q;
    logic               grant_d;
    logic               last_q;
    logic [DW-1:0]      hi_q;
    logic               m_valid_q;
    logic [2*DW-1:0]    m_data_q;
    logic               m_src_q;

    logic               slot_free;
    logic               sel_valid;
    logic [DW-1:0]      sel_data;
    logic               sel_ready;
    logic               accept;

    // The output slot can take a word if it is empty or is draining this cycle.
    assign slot_free = !m_valid_q || m_ready;

    // Steer the granted requester's handshake and decide its ready.
    always_comb begin
        sel_valid = grant_q ? s1_valid : s0_valid;
        sel_data  = grant_q ? s1_data  : s0_data;
        sel_ready = 1'b0;
        case (state_q)
            FIRST:   sel_ready = 1'b1;
            SECOND:  sel_ready = slot_free;
            default: sel_ready = 1'b0;
        endcase
        s0_ready = sel_ready && !grant_q;
        s1_ready = sel_ready &&  grant_q;
        accept   = sel_valid && sel_ready;
    end

    // Round-robin choice used only when leaving IDLE.
    always_comb begin
        grant_d = grant_q;
        if (s0_valid && s1_valid) begin
            grant_d = !last_q;
        end else if (s0_valid) begin
            grant_d = 1'b0;
        end else if (s1_valid) begin
            grant_d = 1'b1;
        end
    end

    // FSM, byte capture and output register. A reset mid-pair drops the
    // captured byte, so a partial word is never emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= LAST_RESET;
            hi_q      <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_src_q   <= 1'b0;
        end else begin
            // A load in SECOND overrides this drain, so a simultaneous drain
            // and load keeps m_valid high with the new word.
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (s0_valid || s1_valid) begin
                        grant_q <= grant_d;
                        state_q <= FIRST;
                    end
                end
                FIRST: begin
                    if (accept) begin
                        hi_q    <= sel_data;
                        state_q <= SECOND;
                    end
                end
                SECOND: begin
                    if (accept) begin
                        m_data_q  <= {hi_q, sel_data};
                        m_src_q   <= grant_q;
                        m_valid_q <= 1'b1;
                        last_q    <= grant_q;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_src   = m_src_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_pack16_rr_arbiter.sv
// Directed bench for pack16_rr_arbiter.
// Each source has a byte queue. Expected words come from a hand-written queue
// and are checked whenever the output handshakes.
module tb_pack16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic        s0_valid;
    logic [7:0]  s0_data;
    logic        s0_ready;
    logic        s1_valid;
    logic [7:0]  s1_data;
    logic        s1_ready;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_src;
    logic        m_ready;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    logic [15:0] expw[$];
    logic        exps[$];
    bit          hold0;
    bit          acc0;
    bit          acc1;
    bit          got;

    pack16_rr_arbiter #(.DW(8), .FIRST_PRIO(0)) dut (
        .clk      (clk),
        .rst      (rst),
        .s0_valid (s0_valid),
        .s0_data  (s0_data),
        .s0_ready (s0_ready),
        .s1_valid (s1_valid),
        .s1_data  (s1_data),
        .s1_ready (s1_ready),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_src    (m_src),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        s0_valid = (q0.size() > 0) && !hold0;
        s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
        s1_valid = (q1.size() > 0);
        s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    // One clock: note which handshakes will fire at the next edge, check any
    // emitted word against the expected queue, then advance the source queues.
    task automatic cyc();
        drive();
        #1;
        acc0 = s0_valid && s0_ready;
        acc1 = s1_valid && s1_ready;
        got  = m_valid && m_ready;
        if (got) begin
            chk("word_expected", 32'(expw.size() != 0), 32'd1);
            if (expw.size() != 0) begin
                chk("word_data", 32'(m_data), 32'(expw[0]));
                chk("word_src", 32'(m_src), 32'(exps[0]));
                void'(expw.pop_front());
                void'(exps.pop_front());
            end
        end
        @(posedge clk);
        #1;
        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q0.delete();
        q1.delete();
        expw.delete();
        exps.delete();
        hold0 = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_m_src"}, 32'(m_src), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_s0_ready"}, 32'(s0_ready), 32'd0);
        chk({tag, "_s1_ready"}, 32'(s1_ready), 32'd0);
    endtask

    initial begin
        m_ready = 1'b0;
        hold0   = 1'b0;
        do_reset();
        #1;
        chk_reset_vals("rst");

        // s0 alone sends A1, B2
        m_ready = 1'b1;
        q0 = '{8'hA1, 8'hB2};
        expw.push_back(16'hA1B2); exps.push_back(1'b0);
        cyc();
        #1;
        chk("t1_first_s0_ready", 32'(s0_ready), 32'd1);
        chk("t1_first_s1_ready", 32'(s1_ready), 32'd0);
        chk("t1_first_busy", 32'(busy), 32'd1);
        cyc();
        #1;
        chk("t1_second_s0_ready", 32'(s0_ready), 32'd1);
        chk("t1_second_m_valid", 32'(m_valid), 32'd0);
        cyc();
        #1;
        chk("t1_out_valid", 32'(m_valid), 32'd1);
        chk("t1_out_data", 32'(m_data), 32'hA1B2);
        chk("t1_out_s1_ready", 32'(s1_ready), 32'd0);
        chk("t1_out_busy", 32'(busy), 32'd0);
        cyc();
        #1;
        chk("t1_valid_one_cycle", 32'(m_valid), 32'd0);
        chk("t1_all_words", 32'(expw.size()), 32'd0);

        // both continuously valid: strict alternation starting with s0
        do_reset();
        m_ready = 1'b1;
        q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        q1 = '{8'h55, 8'h66, 8'h77, 8'h88};
        expw = '{16'h1122, 16'h5566, 16'h3344, 16'h7788};
        exps = '{1'b0, 1'b1, 1'b0, 1'b1};
        repeat (16) cyc();
        chk("t2_all_words", 32'(expw.size()), 32'd0);
        chk("t2_q0_drained", 32'(q0.size()), 32'd0);
        chk("t2_q1_drained", 32'(q1.size()), 32'd0);

        // output backpressure, then simultaneous drain and load
        m_ready = 1'b0;
        q0 = '{8'hA1, 8'hB2};
        q1 = '{8'hC3, 8'hD4};
        expw = '{16'hA1B2, 16'hC3D4};
        exps = '{1'b0, 1'b1};
        repeat (3) cyc();
        #1;
        chk("t3_out_valid", 32'(m_valid), 32'd1);
        chk("t3_out_data", 32'(m_data), 32'hA1B2);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk("t3_hold_valid", 32'(m_valid), 32'd1);
            chk("t3_hold_data", 32'(m_data), 32'hA1B2);
            chk("t3_hold_src", 32'(m_src), 32'd0);
        end
        chk("t3_stall_s1_ready", 32'(s1_ready), 32'd0);
        chk("t3_stall_s0_ready", 32'(s0_ready), 32'd0);
        chk("t3_stall_busy", 32'(busy), 32'd1);
        chk("t3_stall_low_pending", 32'(q1.size()), 32'd1);
        m_ready = 1'b1;
        #1;
        chk("t3_release_s1_ready", 32'(s1_ready), 32'd1);
        cyc();
        #1;
        chk("t3_drain_load_valid", 32'(m_valid), 32'd1);
        chk("t3_drain_load_data", 32'(m_data), 32'hC3D4);
        chk("t3_drain_load_src", 32'(m_src), 32'd1);
        cyc();
        #1;
        chk("t3_after_valid", 32'(m_valid), 32'd0);
        chk("t3_all_words", 32'(expw.size()), 32'd0);

        // s0 pauses mid-pair; the grant stays locked
        q0 = '{8'h5A, 8'hA5};
        q1 = '{8'hF0, 8'hF1};
        expw = '{16'h5AA5, 16'hF0F1};
        exps = '{1'b0, 1'b1};
        repeat (2) cyc();
        hold0 = 1'b1;
        drive();
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            chk("t4_pause_s1_ready", 32'(s1_ready), 32'd0);
            chk("t4_pause_busy", 32'(busy), 32'd1);
            chk("t4_pause_m_valid", 32'(m_valid), 32'd0);
        end
        hold0 = 1'b0;
        cyc();
        #1;
        chk("t4_word_valid", 32'(m_valid), 32'd1);
        chk("t4_word_data", 32'(m_data), 32'h5AA5);
        cyc();
        #1;
        chk("t4_next_grant_s1", 32'(s1_ready), 32'd1);
        chk("t4_next_grant_s0", 32'(s0_ready), 32'd0);
        repeat (3) cyc();
        chk("t4_all_words", 32'(expw.size()), 32'd0);

        // reset while in SECOND holding EE; the pending low byte is offered
        // during the reset edge and must not complete a word
        q0 = '{8'hEE, 8'h99};
        repeat (2) cyc();
        #1;
        chk("t5_in_second_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        drive();
        #1;
        chk_reset_vals("t5_rst");
        q1 = '{8'h01, 8'h02};
        expw = '{16'h0102};
        exps = '{1'b1};
        repeat (6) cyc();
        chk("t5_all_words", 32'(expw.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
